// File: rtl/ram_hs.sv
// Byte-addressed RAM behind a four-phase MOV/MOC handshake.
// Supports byte, halfword and word accesses with configurable wait states and endianness.
module ram_hs #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int BIG_ENDIAN  = 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MOV,
  input  logic              RW,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [1:0]        TYPE,
  input  logic              SEXT,
  input  logic [31:0]       DIN,
  output logic [31:0]       DOUT,
  output logic              MOC,
  output logic              ERR,
  output logic              BUSY
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int AW1   = ADDR_W + 1;
  localparam bit BE    = (BIG_ENDIAN != 0);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [31:0]       dout_reg, dout_next;
  logic              err_reg, err_next;
  logic              rw_reg, sext_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        type_reg;
  logic [31:0]       din_reg;
  logic              capture, do_write, access_err;
  logic [AW1-1:0]    size_m1, end_addr;
  logic [3:0]        lane_mask;
  logic [31:0]       raw, rd_data;

  logic [7:0]        mem [0:DEPTH-1];
  logic [ADDR_W-1:0] lane_addr [4];
  logic [7:0]        lane_rd [4];
  logic [7:0]        wr_lane [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_addr[gi] = addr_reg + ADDR_W'(gi);
      assign lane_rd[gi]   = mem[lane_addr[gi]];
    end
  endgenerate

  // Errors cover reserved size, misalignment and running past the top of memory.
  always_comb begin
    size_m1   = '0;
    lane_mask = 4'b0001;
    case (type_reg)
      2'b00:   begin size_m1 = AW1'(0); lane_mask = 4'b0001; end
      2'b01:   begin size_m1 = AW1'(1); lane_mask = 4'b0011; end
      default: begin size_m1 = AW1'(3); lane_mask = 4'b1111; end
    endcase
    end_addr   = {1'b0, addr_reg} + size_m1;
    access_err = (type_reg == 2'b11)
               | ((type_reg == 2'b01) & addr_reg[0])
               | ((type_reg == 2'b10) & (addr_reg[1:0] != 2'b00))
               | end_addr[ADDR_W];
  end

  always_comb begin
    raw = '0;
    case (type_reg)
      2'b00:   raw[7:0]  = lane_rd[0];
      2'b01:   raw[15:0] = BE ? {lane_rd[0], lane_rd[1]} : {lane_rd[1], lane_rd[0]};
      default: raw = BE ? {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]}
                        : {lane_rd[3], lane_rd[2], lane_rd[1], lane_rd[0]};
    endcase
    case (type_reg)
      2'b00:   rd_data = {{24{sext_reg & raw[7]}}, raw[7:0]};
      2'b01:   rd_data = {{16{sext_reg & raw[15]}}, raw[15:0]};
      default: rd_data = raw;
    endcase
  end

  // Lane k targets byte ADDR+k; the data byte it takes depends on endianness.
  always_comb begin
    for (int k = 0; k < 4; k++) wr_lane[k] = 8'h00;
    case (type_reg)
      2'b00: wr_lane[0] = din_reg[7:0];
      2'b01: begin
        wr_lane[0] = BE ? din_reg[15:8] : din_reg[7:0];
        wr_lane[1] = BE ? din_reg[7:0]  : din_reg[15:8];
      end
      default: begin
        wr_lane[0] = BE ? din_reg[31:24] : din_reg[7:0];
        wr_lane[1] = BE ? din_reg[23:16] : din_reg[15:8];
        wr_lane[2] = BE ? din_reg[15:8]  : din_reg[23:16];
        wr_lane[3] = BE ? din_reg[7:0]   : din_reg[31:24];
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dout_next  = dout_reg;
    err_next   = err_reg;
    capture    = 1'b0;
    do_write   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (MOV) begin
          capture    = 1'b1;
          cnt_next   = 4'(WAIT_CYCLES);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!MOV) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg == 4'd0) begin
          state_next = DONE;
          err_next   = access_err;
          dout_next  = (rw_reg && !access_err) ? rd_data : 32'h0;
          do_write   = !rw_reg && !access_err;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: begin
        if (!MOV) begin
          state_next = IDLE;
          dout_next  = 32'h0;
          err_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      dout_reg  <= 32'h0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dout_reg  <= dout_next;
      err_reg   <= err_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      rw_reg   <= 1'b1;
      addr_reg <= '0;
      type_reg <= 2'b00;
      sext_reg <= 1'b0;
      din_reg  <= 32'h0;
    end else if (capture) begin
      rw_reg   <= RW;
      addr_reg <= ADDR;
      type_reg <= TYPE;
      sext_reg <= SEXT;
      din_reg  <= DIN;
    end
  end

  // Memory contents deliberately survive CLR; a reset in WAIT still blocks the write.
  always_ff @(posedge CLK) begin
    if (do_write && !CLR) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_mask[k]) mem[lane_addr[k]] <= wr_lane[k];
      end
    end
  end

  assign DOUT = dout_reg;
  assign ERR  = err_reg;
  assign MOC  = (state_reg == DONE);
  assign BUSY = (state_reg != IDLE);
endmodule

// File: tb/tb_ram_hs.sv
// Directed checks of ram_hs: big-endian/2-wait instance and little-endian/0-wait instance.
module tb_ram_hs;
  logic        clk = 1'b0;
  logic        clr, rw, sext, mov_a, mov_b;
  logic [7:0]  addr;
  logic [1:0]  typ;
  logic [31:0] din, dout_a, dout_b;
  logic        moc_a, moc_b, err_a, err_b, busy_a, busy_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ram_hs dut_a (
    .CLK(clk), .CLR(clr), .MOV(mov_a), .RW(rw), .ADDR(addr), .TYPE(typ), .SEXT(sext),
    .DIN(din), .DOUT(dout_a), .MOC(moc_a), .ERR(err_a), .BUSY(busy_a)
  );

  ram_hs #(.ADDR_W(8), .WAIT_CYCLES(0), .BIG_ENDIAN(0)) dut_b (
    .CLK(clk), .CLR(clr), .MOV(mov_b), .RW(rw), .ADDR(addr), .TYPE(typ), .SEXT(sext),
    .DIN(din), .DOUT(dout_b), .MOC(moc_b), .ERR(err_b), .BUSY(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // One full handshake; checks latency (edges from capture to MOC), data, error and MOC release.
  task automatic do_req(input bit sel, input string tag, input logic r, input logic [7:0] a,
                        input logic [1:0] t, input logic s, input logic [31:0] dv,
                        input int exp_lat, input logic [31:0] exp_dout, input logic exp_err);
    int   lat;
    logic seen;
    rw = r; addr = a; typ = t; sext = s; din = dv;
    if (sel) mov_b = 1'b1; else mov_a = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      seen = sel ? moc_b : moc_a;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_dout"}, sel ? dout_b : dout_a, exp_dout);
    check({tag, "_err"}, {31'b0, sel ? err_b : err_a}, {31'b0, exp_err});
    mov_a = 1'b0;
    mov_b = 1'b0;
    @(posedge clk); #1;
    check({tag, "_moc_fall"}, {31'b0, sel ? moc_b : moc_a}, 32'h0);
  endtask

  initial begin
    logic seen;
    int   n;
    clr = 1'b1; mov_a = 1'b0; mov_b = 1'b0;
    rw = 1'b1; addr = 8'h00; typ = 2'b00; sext = 1'b0; din = 32'h0;

    dut_a.mem[0] = 8'hE3; dut_a.mem[1] = 8'hA0; dut_a.mem[2] = 8'h00; dut_a.mem[3] = 8'h05;
    dut_a.mem[4] = 8'h11; dut_a.mem[5] = 8'h22; dut_a.mem[6] = 8'h33; dut_a.mem[7] = 8'h44;
    dut_a.mem[9] = 8'h80;
    dut_a.mem[252] = 8'hDE; dut_a.mem[253] = 8'hAD; dut_a.mem[254] = 8'hBE; dut_a.mem[255] = 8'hEF;
    dut_b.mem[0] = 8'hE3; dut_b.mem[1] = 8'hA0; dut_b.mem[2] = 8'h00; dut_b.mem[3] = 8'h05;
    dut_b.mem[4] = 8'h11; dut_b.mem[5] = 8'h22;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy_a}, 32'h0);
    check("rst_moc", {31'b0, moc_a}, 32'h0);
    check("rst_err", {31'b0, err_a}, 32'h0);
    check("rst_dout", dout_a, 32'h0);
    clr = 1'b0;

    do_req(0, "rd_w0",     1'b1, 8'h00, 2'b10, 1'b0, 32'h0,        4, 32'hE3A00005, 1'b0);
    do_req(0, "wr_h6",     1'b0, 8'h06, 2'b01, 1'b0, 32'h0000BEEF, 4, 32'h0,        1'b0);
    do_req(0, "rd_w4",     1'b1, 8'h04, 2'b10, 1'b0, 32'h0,        4, 32'h1122BEEF, 1'b0);
    do_req(0, "rd_b9_sx",  1'b1, 8'h09, 2'b00, 1'b1, 32'h0,        4, 32'hFFFFFF80, 1'b0);
    do_req(0, "rd_b9_zx",  1'b1, 8'h09, 2'b00, 1'b0, 32'h0,        4, 32'h00000080, 1'b0);
    do_req(0, "rd_h6_sx",  1'b1, 8'h06, 2'b01, 1'b1, 32'h0,        4, 32'hFFFFBEEF, 1'b0);
    do_req(0, "wr_w2_mis", 1'b0, 8'h02, 2'b10, 1'b0, 32'h12345678, 4, 32'h0,        1'b1);
    do_req(0, "wr_t3",     1'b0, 8'h00, 2'b11, 1'b0, 32'hFFFFFFFF, 4, 32'h0,        1'b1);
    do_req(0, "rd_w0_chk", 1'b1, 8'h00, 2'b10, 1'b0, 32'h0,        4, 32'hE3A00005, 1'b0);
    do_req(0, "rd_wFC",    1'b1, 8'hFC, 2'b10, 1'b0, 32'h0,        4, 32'hDEADBEEF, 1'b0);
    do_req(0, "rd_hFF",    1'b1, 8'hFF, 2'b01, 1'b0, 32'h0,        4, 32'h0,        1'b1);

    // Abort a byte write by dropping MOV in WAIT.
    rw = 1'b0; addr = 8'h09; typ = 2'b00; din = 32'h000000AA; mov_a = 1'b1;
    @(posedge clk); #1;
    check("abort_busy_wait", {31'b0, busy_a}, 32'h1);
    mov_a = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", {31'b0, busy_a}, 32'h0);
    seen = moc_a;
    repeat (4) begin @(posedge clk); #1; seen |= moc_a; end
    check("abort_moc", {31'b0, seen}, 32'h0);
    do_req(0, "abort_rd9", 1'b1, 8'h09, 2'b00, 1'b0, 32'h0, 4, 32'h00000080, 1'b0);

    // Cancel a byte write with CLR in WAIT while MOV is still high.
    rw = 1'b0; addr = 8'h09; typ = 2'b00; din = 32'h00000055; mov_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    check("clr_busy", {31'b0, busy_a}, 32'h0);
    clr = 1'b0; mov_a = 1'b0;
    seen = moc_a;
    repeat (4) begin @(posedge clk); #1; seen |= moc_a; end
    check("clr_moc", {31'b0, seen}, 32'h0);
    do_req(0, "clr_rd9", 1'b1, 8'h09, 2'b00, 1'b0, 32'h0, 4, 32'h00000080, 1'b0);

    // MOV held in DONE must keep the single completed access.
    rw = 1'b1; addr = 8'h00; typ = 2'b10; sext = 1'b0; mov_a = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin @(posedge clk); #1; n++; seen = moc_a; end
    check("hold_lat", n, 4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold_moc%0d", i), {31'b0, moc_a}, 32'h1);
      check($sformatf("hold_dout%0d", i), dout_a, 32'hE3A00005);
    end
    mov_a = 1'b0;
    @(posedge clk); #1;
    check("hold_moc_fall", {31'b0, moc_a}, 32'h0);
    seen = busy_a;
    repeat (3) begin @(posedge clk); #1; seen |= busy_a; end
    check("hold_no_restart", {31'b0, seen}, 32'h0);

    // Little-endian instance with no wait states.
    do_req(1, "b_rd_w0",    1'b1, 8'h00, 2'b10, 1'b0, 32'h0,        2, 32'h0500A0E3, 1'b0);
    do_req(1, "b_wr_h6",    1'b0, 8'h06, 2'b01, 1'b0, 32'h0000BEEF, 2, 32'h0,        1'b0);
    do_req(1, "b_rd_w4",    1'b1, 8'h04, 2'b10, 1'b0, 32'h0,        2, 32'hBEEF2211, 1'b0);
    do_req(1, "b_rd_h6_sx", 1'b1, 8'h06, 2'b01, 1'b1, 32'h0,        2, 32'hFFFFBEEF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_hs.md
RAM_HS -- requirements
Module: ram_hs

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; memory depth = 2**ADDR_W bytes.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before completion, range 0..15.
REQ-003 Parameter BIG_ENDIAN, default 1; 1 = byte at ADDR is most significant, 0 = least significant.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 CLR  input  1  reset, synchronous, active-high.
REQ-006 MOV  input  1  memory operation valid (request), held high until MOC seen.
REQ-007 RW  input  1  1 = read, 0 = write; sampled with request.
REQ-008 ADDR  input  ADDR_W  byte address; sampled with request.
REQ-009 TYPE  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 SEXT  input  1  1 = sign-extend byte/halfword reads, 0 = zero-extend.
REQ-011 DIN  input  32  write data, right-justified; sampled with request.
REQ-012 DOUT  output  32  read data, valid while MOC=1 and RW was 1.
REQ-013 MOC  output  1  memory operation complete.
REQ-014 ERR  output  1  error flag, valid while MOC=1.
REQ-015 BUSY  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, DONE; BUSY = (state != IDLE).
REQ-017 In IDLE with MOV=1 at an edge, the block SHALL latch RW, ADDR, TYPE, SEXT and DIN, load the counter with WAIT_CYCLES and go to WAIT.
REQ-018 In WAIT, the counter SHALL decrement each edge; at the edge where the counter is 0, the block SHALL perform the access and enter DONE.
REQ-019 Latency: counting the capturing edge as edge 1, MOC SHALL rise after edge WAIT_CYCLES+2 (WAIT_CYCLES=2 -> after edge 4).
REQ-020 In DONE, MOC SHALL be 1 and DOUT/ERR held stable; the block SHALL leave DONE for IDLE on the first edge with MOV=0 (four-phase handshake).
REQ-021 The block SHALL accept a new request only in IDLE; MOV remaining high in DONE SHALL NOT start a second access.
REQ-022 MOV=0 during WAIT SHALL abort: return to IDLE next edge, no memory write, MOC never asserted.
REQ-023 ERR SHALL be set for TYPE=11, for misalignment (halfword with ADDR[0]=1, word with ADDR[1:0]!=0), or for ADDR+size-1 > 2**ADDR_W-1.
REQ-024 On ERR, the block SHALL NOT modify memory and SHALL drive DOUT=0; the handshake SHALL complete normally.
REQ-025 Big-endian read SHALL give byte {ext24, m[A]}, halfword {ext16, m[A], m[A+1]}, word {m[A], m[A+1], m[A+2], m[A+3]}; little-endian SHALL reverse the byte order.
REQ-026 ext SHALL be replicated copies of the MSB of the loaded byte/halfword when SEXT=1, zeros otherwise.
REQ-027 Writes SHALL store DIN[7:0], DIN[15:0] or DIN[31:0] in the same byte order as reads; bytes outside the access SHALL be unchanged.
REQ-028 Outside DONE, DOUT SHALL be 0 and ERR SHALL be 0.
REQ-029 The memory array SHALL be accessible hierarchically as mem[0:2**ADDR_W-1] of 8 bits for bench preload.

Reset
REQ-030 CLR=1 at an edge SHALL force IDLE, MOC=0, ERR=0, BUSY=0, DOUT=0 and counter=0, overriding MOV.
REQ-031 CLR SHALL NOT clear memory contents.
REQ-032 CLR asserted in WAIT SHALL cancel the access with no memory write.

Verification
REQ-033 Preload m[0..3]=E3,A0,00,05, request word read at ADDR=0, WAIT_CYCLES=2 -> MOC rises after edge 4, DOUT=E3A00005, ERR=0; MOC falls one edge after MOV drops.
REQ-034 Write halfword DIN=0000BEEF to ADDR=6, then read word at ADDR=4 -> m[6]=BE, m[7]=EF, m[4], m[5] unchanged.
REQ-035 Preload m[9]=80, byte read at ADDR=9 with SEXT=1 -> FFFFFF80; with SEXT=0 -> 00000080.
REQ-036 Word write to ADDR=2 (misaligned) and TYPE=11 -> MOC=1, ERR=1, DOUT=0, memory unchanged; word read at ADDR=FC ok, halfword at FF -> ERR=1.
REQ-037 Drop MOV in WAIT on a write, or assert CLR in WAIT -> next edge IDLE, BUSY=0, MOC never 1, target bytes unchanged.
REQ-038 Hold MOV high for 3 edges in DONE, then WAIT_CYCLES=0 run -> exactly one access per handshake; MOC after edge 2.
